// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: control/address sequencer for a weight-stationary systolic matmul.
// Per weight tile: load NUM_ROWS weight rows, stream M input vectors, drain the
// PIPE_LAT-deep result pipe into the output memory, then move to the next tile.
// Ports: clk, rst_n (sync, active low); i_start/i_m_len/i_num_tiles (run config,
// latched on start); i_hold (global stall); o_busy/o_done (run status);
// o_w_rd_*/o_w_load (weight path); o_in_rd_*/o_in_valid (input path);
// o_array_en (array clock enable); o_out_wr_* (result write port).
// Optional SA_SEQ_PERF_EN adds o_cycle_count (saturating busy-cycle count).
module sa_tile_sequencer #(
  parameter int NUM_ROWS  = 4,
  parameter int NUM_COLS  = 4,
  parameter int MAX_M     = 64,
  parameter int MAX_TILES = 8,
  parameter int PIPE_LAT  = NUM_ROWS + NUM_COLS
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_start,
  input  logic [$clog2(MAX_M+1)-1:0]            i_m_len,
  input  logic [$clog2(MAX_TILES+1)-1:0]        i_num_tiles,
  input  logic                                  i_hold,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_w_rd_en,
  output logic [$clog2(MAX_TILES*NUM_ROWS)-1:0] o_w_rd_addr,
  output logic                                  o_w_load,
  output logic                                  o_in_rd_en,
  output logic [$clog2(MAX_M)-1:0]              o_in_rd_addr,
  output logic                                  o_in_valid,
  output logic                                  o_array_en,
  output logic                                  o_out_wr_en,
  output logic [$clog2(MAX_TILES*MAX_M)-1:0]    o_out_wr_addr
`ifdef SA_SEQ_PERF_EN
  , output logic [31:0]                         o_cycle_count
`endif
);
  localparam int CW  = $clog2(NUM_ROWS+1);
  localparam int MW  = $clog2(MAX_M+1);
  localparam int TW  = $clog2(MAX_TILES+1);
  localparam int WAW = $clog2(MAX_TILES*NUM_ROWS);
  localparam int IAW = $clog2(MAX_M);
  localparam int OAW = $clog2(MAX_TILES*MAX_M);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [MW-1:0] s_q, s_d, k_q, k_d, m_q, m_d, m_sat;
  logic [TW-1:0] t_q, t_d, nt_q, nt_d, t_sat;
  logic [PIPE_LAT-1:0] pipe_q, pipe_d;
  logic w_load_q, w_load_d, in_valid_q, in_valid_d;
  logic en, w_rd, in_rd, drained;
  // Hold only stalls an active run; in IDLE the sequencer keeps listening for start.
  assign en      = ~i_hold | (state_q == IDLE);
  assign w_rd    = (state_q == LOAD_W) && (c_q < CW'(NUM_ROWS));
  assign in_rd   = (state_q == STREAM);
  // The tail bit may be writing this cycle; nothing behind it means the tile is finished.
  assign drained = ~in_valid_q && (pipe_q[PIPE_LAT-2:0] == '0);
  assign m_sat   = (i_m_len > MW'(MAX_M)) ? MW'(MAX_M) : i_m_len;
  assign t_sat   = (i_num_tiles > TW'(MAX_TILES)) ? TW'(MAX_TILES) : i_num_tiles;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      c_q        <= '0;
      s_q        <= '0;
      k_q        <= '0;
      t_q        <= '0;
      m_q        <= '0;
      nt_q       <= '0;
      pipe_q     <= '0;
      w_load_q   <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      s_q        <= s_d;
      k_q        <= k_d;
      t_q        <= t_d;
      m_q        <= m_d;
      nt_q       <= nt_d;
      pipe_q     <= pipe_d;
      w_load_q   <= w_load_d;
      in_valid_q <= in_valid_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    s_d        = s_q;
    k_d        = k_q;
    t_d        = t_q;
    m_d        = m_q;
    nt_d       = nt_q;
    pipe_d     = en ? {pipe_q[PIPE_LAT-2:0], in_valid_q} : pipe_q;
    w_load_d   = en ? w_rd : w_load_q;
    in_valid_d = en ? in_rd : in_valid_q;
    if (en) begin
      if (pipe_q[PIPE_LAT-1]) k_d = k_q + MW'(1);
      unique case (state_q)
        IDLE: if (i_start) begin
          m_d     = m_sat;
          nt_d    = t_sat;
          t_d     = '0;
          c_d     = '0;
          s_d     = '0;
          k_d     = '0;
          state_d = (m_sat == '0 || t_sat == '0) ? DONE : LOAD_W;
        end
        LOAD_W: begin
          c_d = c_q + CW'(1);
          if (c_q == CW'(NUM_ROWS)) begin
            s_d     = '0;
            state_d = STREAM;
          end
        end
        STREAM: begin
          s_d = s_q + MW'(1);
          if (s_q == m_q - MW'(1)) state_d = DRAIN;
        end
        DRAIN: if (drained) begin
          if (t_q + TW'(1) < nt_q) begin
            t_d     = t_q + TW'(1);
            c_d     = '0;
            k_d     = '0;
            state_d = LOAD_W;
          end else begin
            state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    o_busy        = state_q != IDLE;
    o_done        = (state_q == DONE) & ~i_hold;
    o_w_rd_en     = w_rd & ~i_hold;
    o_w_rd_addr   = WAW'(t_q) * WAW'(NUM_ROWS) + WAW'(c_q);
    o_w_load      = w_load_q & ~i_hold;
    o_in_rd_en    = in_rd & ~i_hold;
    o_in_rd_addr  = s_q[IAW-1:0];
    o_in_valid    = in_valid_q & ~i_hold;
    o_array_en    = (state_q != IDLE) & ~i_hold;
    o_out_wr_en   = pipe_q[PIPE_LAT-1] & ~i_hold;
    o_out_wr_addr = OAW'(t_q) * OAW'(MAX_M) + OAW'(k_q);
  end
`ifdef SA_SEQ_PERF_EN
  logic [31:0] cnt_q, cnt_d;
  // Loading 1 on start counts the start-following cycle, so the value shown in
  // the DONE cycle already equals the number of busy cycles and then stays put.
  assign cnt_d = (state_q == IDLE && i_start) ? 32'd1 :
                 (state_q != IDLE && state_q != DONE && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign o_cycle_count = cnt_q;
`endif
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// tb_sa_tile_sequencer: directed table-driven bench for sa_tile_sequencer.
module tb_sa_tile_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_hold = 1'b0;
  logic [6:0] i_m_len = '0;
  logic [3:0] i_num_tiles = '0;
  logic       o_busy, o_done, o_w_rd_en, o_w_load, o_in_rd_en, o_in_valid, o_array_en, o_out_wr_en;
  logic [4:0] o_w_rd_addr;
  logic [5:0] o_in_rd_addr;
  logic [8:0] o_out_wr_addr;
`ifdef SA_SEQ_PERF_EN
  logic [31:0] o_cycle_count;
`endif
  sa_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_m_len(i_m_len), .i_num_tiles(i_num_tiles),
    .i_hold(i_hold), .o_busy(o_busy), .o_done(o_done), .o_w_rd_en(o_w_rd_en),
    .o_w_rd_addr(o_w_rd_addr), .o_w_load(o_w_load), .o_in_rd_en(o_in_rd_en),
    .o_in_rd_addr(o_in_rd_addr), .o_in_valid(o_in_valid), .o_array_en(o_array_en),
    .o_out_wr_en(o_out_wr_en), .o_out_wr_addr(o_out_wr_addr)
`ifdef SA_SEQ_PERF_EN
    , .o_cycle_count(o_cycle_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int m, t, hold_at, hold_len, restart_at, em, et, edone;
  } vec_t;
  vec_t tbl[8];
  int vectors = 0, errors = 0;
  int wq[$], iq[$], oq[$], vcyc[$];
  logic [4:0] lg [0:399];
  int done_n, dcyc, busy_bad, hold_bad, gap_bad, wl_n, post_bad;
  longint cc_done;
  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [27:0] outs();
    return {o_busy, o_done, o_w_rd_en, o_w_rd_addr, o_w_load, o_in_rd_en, o_in_rd_addr,
            o_in_valid, o_array_en, o_out_wr_en, o_out_wr_addr};
  endfunction
  task automatic run(input vec_t v);
    int ew[$], ei[$], eo[$];
    wq.delete(); iq.delete(); oq.delete(); vcyc.delete();
    done_n = 0; dcyc = 0; busy_bad = 0; hold_bad = 0; gap_bad = 0; wl_n = 0; post_bad = 0; cc_done = 0;
    for (int n = 0; n < 400; n++) lg[n] = '0;
    @(negedge clk);
    i_m_len = 7'(v.m); i_num_tiles = 4'(v.t); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 1; n < 400; n++) begin
      i_hold = (n >= v.hold_at) && (n < v.hold_at + v.hold_len);
      if (n == v.restart_at) begin
        i_start = 1'b1; i_m_len = 7'd5; i_num_tiles = 4'd2;
      end else i_start = 1'b0;
      #1;
      lg[n] = {o_w_rd_en, o_w_load, o_in_rd_en, o_in_valid, o_out_wr_en};
      if (o_w_rd_en) wq.push_back(int'(o_w_rd_addr));
      if (o_w_load) wl_n++;
      if (o_in_rd_en) iq.push_back(int'(o_in_rd_addr));
      if (o_in_valid) vcyc.push_back(n);
      if (o_out_wr_en) begin
        oq.push_back(int'(o_out_wr_addr));
        if (vcyc.size() > 0) begin
          if (v.hold_len == 0 && n - vcyc[0] != 8) gap_bad++;
          void'(vcyc.pop_front());
        end else gap_bad++;
      end
      if (!o_busy) busy_bad++;
      if (i_hold && (lg[n] != '0 || o_array_en)) hold_bad++;
      if (!i_hold && !o_array_en) hold_bad++;
      if (o_done) begin
        done_n++; dcyc = n;
`ifdef SA_SEQ_PERF_EN
        cc_done = longint'(o_cycle_count);
`endif
      end
      @(negedge clk);
      if (done_n != 0) break;
    end
    i_hold = 1'b0; i_start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      if (o_done) done_n++;
      if (o_busy || o_w_rd_en || o_in_rd_en || o_out_wr_en) post_bad++;
`ifdef SA_SEQ_PERF_EN
      if (longint'(o_cycle_count) != cc_done) post_bad++;
`endif
      @(negedge clk);
    end
    for (int tt = 0; tt < v.et; tt++) begin
      for (int c = 0; c < 4; c++) ew.push_back(tt*4 + c);
      for (int i = 0; i < v.em; i++) begin
        ei.push_back(i);
        eo.push_back(tt*64 + i);
      end
    end
    chk("done_cycle", dcyc, v.edone);
    chk("done_count", done_n, 1);
    chk("busy_gaps", busy_bad, 0);
    chk("hold_strobes", hold_bad, 0);
    chk("valid_to_write", gap_bad, 0);
    chk("post_done_idle", post_bad, 0);
    chk("w_load_count", wl_n, 4*v.et);
`ifdef SA_SEQ_PERF_EN
    chk("cycle_count", cc_done, v.edone);
`endif
    chk("w_addr_count", wq.size(), ew.size());
    foreach (ew[i]) chk($sformatf("w_addr[%0d]", i), i < wq.size() ? wq[i] : -1, ew[i]);
    chk("in_addr_count", iq.size(), ei.size());
    foreach (ei[i]) chk($sformatf("in_addr[%0d]", i), i < iq.size() ? iq[i] : -1, ei[i]);
    chk("out_addr_count", oq.size(), eo.size());
    foreach (eo[i]) chk($sformatf("out_addr[%0d]", i), i < oq.size() ? oq[i] : -1, eo[i]);
  endtask
  initial begin
    //          m   t  hold_at len restart em  et  edone
    tbl[0] = '{  3,  1,  0,   0,   3,     3,  1,  18};
    tbl[1] = '{  2,  2,  0,   0,   0,     2,  2,  33};
    tbl[2] = '{  0,  3,  0,   0,   0,     0,  0,   1};
    tbl[3] = '{  5,  0,  0,   0,   0,     0,  0,   1};
    tbl[4] = '{  8,  1,  8,   5,   0,     8,  1,  28};
    tbl[5] = '{  8,  1,  0,   0,   0,     8,  1,  23};
    tbl[6] = '{100,  1,  0,   0,   0,    64,  1,  79};
    tbl[7] = '{  1,  9,  0,   0,   0,     1,  8, 121};
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", longint'(outs()), 0);
    rst_n = 1'b1;
    run(tbl[0]);
    for (int n = 1; n <= 18; n++)
      chk($sformatf("m3_strobes_c%0d", n), longint'(lg[n]),
          longint'({n <= 4, n >= 2 && n <= 5, n >= 6 && n <= 8, n >= 7 && n <= 9, n >= 15 && n <= 17}));
    for (int i = 0; i < 8; i++) run(tbl[i]);
    @(negedge clk);
    i_m_len = 7'd2; i_num_tiles = 4'd2; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("pre_reset_busy", longint'(o_busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_outputs", longint'(outs()), 0);
    rst_n = 1'b1;
    post_bad = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      if (o_done || o_busy) post_bad++;
    end
    chk("abort_no_done", post_bad, 0);
    run(tbl[1]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
